ifu_thr_pc_gen: RTL and testbench
=================================

# ifu_thr_pc_gen

Per-thread fetch PC generator for the IFU S/F boundary of one SPARC core. Holds a 48-bit PC for each of the four strands and round-robin selects one running strand per cycle into the F-stage. Drives `pc_f`, the one-hot `thr_f` and `inst_vld_f`, and publishes all four per-thread PCs. The block guarantees by construction that `pc_f` always equals the selected thread's `tNpc_f`.

## Interface
Parameters:
- `PC_W`, 48: PC width in bits.
- `RST_PC`, 48'h0000_00ff_f000_0020: PC loaded into every thread on reset (power-on vector).

Ports:
- `clk`  in  1  core clock; all state changes on posedge.
- `rst`  in  1  asynchronous, active-high reset.
- `thr_en`  in  4  per-thread running enable (bit n = thread n).
- `stall_f`  in  1  F-stage stall; holds selection and PC advance.
- `redirect_vld`  in  1  PC redirect (branch/trap) this cycle.
- `redirect_thr`  in  2  thread id of the redirect.
- `redirect_pc`  in  PC_W  redirect target.
- `thr_f`  out  4  one-hot thread in F (all-zero when idle).
- `inst_vld_f`  out  1  F slot holds a valid fetch.
- `pc_f`  out  PC_W  PC of the F-stage thread.
- `t0pc_f` / `t1pc_f` / `t2pc_f` / `t3pc_f`  out  PC_W  per-thread current PC.
- `kill_f`  out  1  the F-stage fetch is killed by a same-cycle redirect.

## Operation
State:
- Four PC registers.
- Registered `thr_f` and `inst_vld_f`.
- 2-bit round-robin pointer `last_thr`.

Selection (when `stall_f`=0):
- Search `thr_en` starting at `last_thr+1` (mod 4) for the first set bit.
- On a hit: `thr_f` <= one-hot(hit), `inst_vld_f` <= 1, `last_thr` <= hit.
- On no hit: `thr_f` <= 0, `inst_vld_f` <= 0, `last_thr` unchanged.

PC mux:
- `pc_f` = AND-OR of the `tNpc_f` registers gated by `thr_f`. It is purely combinational, with no extra register.
- `pc_f` = 0 when `thr_f`=0.

PC update per thread n, in priority order:
1. `redirect_vld` && `redirect_thr`==n: load `{redirect_pc[PC_W-1:2], 2'b00}`. This applies even when `stall_f`=1.
2. Otherwise, if `inst_vld_f` && `thr_f[n]` && !`stall_f`: PC <= PC + 4, modulo 2^PC_W (wraps to 0).
3. Otherwise: hold.

Redirect vs. fetch in flight:
- `kill_f` = `redirect_vld` && `inst_vld_f` && `thr_f[redirect_thr]`.
- When `kill_f` is asserted, the increment for that thread is suppressed (rule 1 wins).
- If `stall_f`=1 while killed, `inst_vld_f` clears at the next edge and `thr_f` holds.

Stall:
- `thr_f`, `inst_vld_f` and `last_thr` hold.
- PCs hold, except for redirects.

Thread disable:
- Dropping `thr_en[n]` while thread n is in F does not kill the slot.
- Thread n is simply not reselected, and its PC is retained.

Reset:
- PCs = `RST_PC`, `thr_f` = 0, `inst_vld_f` = 0, `last_thr` = 3 (so T0 wins first).
- `kill_f` = 0 and `pc_f` = 0 during reset.

## Timing
- Selection latency: `thr_en` set at cycle N gives `inst_vld_f` at N+1.
- PC advance: visible on `tNpc_f` and `pc_f` the cycle after the fetch completes. A single running thread therefore fetches PC, PC+4, PC+8 on consecutive cycles.
- Redirect latency: `redirect_vld` at cycle N gives the new PC on `tNpc_f` at N+1.
  - If the thread is reselected at N+1, `pc_f` = target at N+1.
- `kill_f` is same-cycle combinational from `redirect_*`.
- Asynchronous reset takes effect immediately, mid-stall or mid-redirect. Deassertion is synchronised externally.
- Invariant (every negedge while `inst_vld_f`): `pc_f` == `tNpc_f` of the `thr_f` thread, and `thr_f` is one-hot.

## Structure
- Shared package `ifu_pc_pkg`: `PC_W`, `RST_PC`, `NTHR`=4, `INST_BYTES`=4, and the thread-id typedef (2 bits).
- One sub-module: `ifu_rr_arb4`, a 4-request round-robin arbiter. Inputs: requests, `last`, `advance`. Outputs: one-hot grant, encoded grant, hit.
- PC registers, update logic and the output mux live in the top level.

## Test plan
- Reset release, `thr_en`=4'b0001, no stall:
  - `inst_vld_f`=1 from cycle 1.
  - `pc_f` = 0xfff0000020, then 0x…24, then 0x…28.
- `thr_en`=4'b1111:
  - `thr_f` sequence is 0001, 0010, 0100, 1000, 0001.
  - Each thread advances by 4 only on its own slot, and `pc_f` matches `tNpc_f` each cycle.
- `stall_f`=1 for 3 cycles with T2 in F: `thr_f`=0100, `pc_f` and all PCs constant; T3 is selected the cycle after release.
- Redirect while in F (T1 in F, `redirect_thr`=1, `redirect_pc`=0x1003):
  - `kill_f`=1 that cycle.
  - `t1pc_f`=0x1000 next cycle, with no +4 applied.
- Wrap-around: T0 loaded to 0xffff_ffff_fffc and fetched once → `t0pc_f`=0.
- Reset asserted mid-stream with pending redirect and stall: all outputs return to reset values immediately, and T0 is first after release.

Source files
------------

// File: rtl/ifu_pc_pkg.sv
// rtl/ifu_pc_pkg.sv - shared IFU fetch-PC constants and thread-id type
package ifu_pc_pkg;

   localparam int          PC_W       = 48;
   localparam logic [47:0] RST_PC     = 48'h0000_00ff_f000_0020;
   localparam int          NTHR       = 4;
   localparam int          INST_BYTES = 4;

   typedef logic [1:0] thr_id_t;

endpackage

// File: rtl/ifu_thr_pc_gen_if.sv
// rtl/ifu_thr_pc_gen_if.sv - control inputs and F-stage outputs of the per-thread PC generator
interface ifu_thr_pc_gen_if #(
   parameter int PC_W = ifu_pc_pkg::PC_W
);
   import ifu_pc_pkg::*;

   logic [NTHR-1:0] thr_en;
   logic            stall_f;
   logic            redirect_vld;
   thr_id_t         redirect_thr;
   logic [PC_W-1:0] redirect_pc;

   logic [NTHR-1:0] thr_f;
   logic            inst_vld_f;
   logic [PC_W-1:0] pc_f;
   logic [PC_W-1:0] t0pc_f;
   logic [PC_W-1:0] t1pc_f;
   logic [PC_W-1:0] t2pc_f;
   logic [PC_W-1:0] t3pc_f;
   logic            kill_f;

   // master: the pipeline control side; slave: the PC generator
   modport master (
      output thr_en, stall_f, redirect_vld, redirect_thr, redirect_pc,
      input  thr_f, inst_vld_f, pc_f, t0pc_f, t1pc_f, t2pc_f, t3pc_f, kill_f
   );

   modport slave (
      input  thr_en, stall_f, redirect_vld, redirect_thr, redirect_pc,
      output thr_f, inst_vld_f, pc_f, t0pc_f, t1pc_f, t2pc_f, t3pc_f, kill_f
   );

endinterface

// File: rtl/ifu_rr_arb4.sv
// rtl/ifu_rr_arb4.sv - 4-request round-robin arbiter, search starts after the last grant
module ifu_rr_arb4
   import ifu_pc_pkg::*;
(
   input  logic [NTHR-1:0] req,
   input  thr_id_t         last,
   input  logic            advance,
   output logic [NTHR-1:0] gnt_oh,
   output thr_id_t         gnt_id,
   output logic            hit
);

   thr_id_t cand;

   always_comb begin
      gnt_oh = '0;
      gnt_id = last;
      hit    = 1'b0;
      cand   = last;
      // k == NTHR wraps back onto last itself, so a lone requester keeps winning
      for (int k = 1; k <= NTHR; k++) begin
         cand = last + thr_id_t'(k);
         if (advance && !hit && req[cand]) begin
            hit    = 1'b1;
            gnt_id = cand;
         end
      end
      if (hit) begin
         gnt_oh[gnt_id] = 1'b1;
      end
   end

endmodule

// File: rtl/ifu_thr_pc_gen.sv
// rtl/ifu_thr_pc_gen.sv - per-thread fetch PC registers, round-robin F-stage select and PC mux
module ifu_thr_pc_gen #(
   parameter int              PC_W   = ifu_pc_pkg::PC_W,
   parameter logic [PC_W-1:0] RST_PC = PC_W'(ifu_pc_pkg::RST_PC)
) (
   input  logic               clk,
   input  logic               rst,
   ifu_thr_pc_gen_if.slave    bus
);
   import ifu_pc_pkg::*;

   thr_id_t         last_thr;
   logic [NTHR-1:0] thr_f_q;
   logic            inst_vld_q;
   logic [PC_W-1:0] pc_q [NTHR];

   logic [NTHR-1:0] gnt_oh;
   thr_id_t         gnt_id;
   logic            hit;
   logic            kill;
   logic [PC_W-1:0] redir_tgt;
   logic [PC_W-1:0] pc_mux;

   ifu_rr_arb4 u_arb (
      .req     (bus.thr_en),
      .last    (last_thr),
      .advance (!bus.stall_f),
      .gnt_oh  (gnt_oh),
      .gnt_id  (gnt_id),
      .hit     (hit)
   );

   assign kill      = bus.redirect_vld & inst_vld_q & thr_f_q[bus.redirect_thr];
   assign redir_tgt = bus.redirect_pc & ~PC_W'(INST_BYTES - 1);

   // A killed slot under stall keeps thr_f so the pipe still knows which strand it was
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         thr_f_q    <= '0;
         inst_vld_q <= 1'b0;
         last_thr   <= thr_id_t'(NTHR - 1);
      end else if (!bus.stall_f) begin
         thr_f_q    <= gnt_oh;
         inst_vld_q <= hit;
         if (hit) begin
            last_thr <= gnt_id;
         end
      end else if (kill) begin
         inst_vld_q <= 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int n = 0; n < NTHR; n++) begin
            pc_q[n] <= RST_PC;
         end
      end else begin
         for (int n = 0; n < NTHR; n++) begin
            if (bus.redirect_vld && bus.redirect_thr == thr_id_t'(n)) begin
               pc_q[n] <= redir_tgt;
            end else if (inst_vld_q && thr_f_q[n] && !bus.stall_f) begin
               pc_q[n] <= pc_q[n] + PC_W'(INST_BYTES);
            end
         end
      end
   end

   // AND-OR mux: pc_f tracks the selected register with no extra pipeline stage
   always_comb begin
      pc_mux = '0;
      for (int n = 0; n < NTHR; n++) begin
         pc_mux = pc_mux | (pc_q[n] & {PC_W{thr_f_q[n]}});
      end
   end

   assign bus.thr_f      = thr_f_q;
   assign bus.inst_vld_f = inst_vld_q;
   assign bus.pc_f       = pc_mux;
   assign bus.t0pc_f     = pc_q[0];
   assign bus.t1pc_f     = pc_q[1];
   assign bus.t2pc_f     = pc_q[2];
   assign bus.t3pc_f     = pc_q[3];
   assign bus.kill_f     = kill;

endmodule

// File: tb/tb_ifu_thr_pc_gen.sv
// tb/tb_ifu_thr_pc_gen.sv - directed and randomized bench for ifu_thr_pc_gen
module tb_ifu_thr_pc_gen;
   import ifu_pc_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   ifu_thr_pc_gen_if bus ();

   ifu_thr_pc_gen dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   int checks = 0;
   int errors = 0;

   // reference: strand PCs, which strand occupies F (-1 = none), slot validity, last winner
   logic [47:0] m_pc [4];
   bit          m_vld;
   int          m_sel;
   int          m_last;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int n = 0; n < 4; n++) m_pc[n] = 48'h00ff_f000_0020;
      m_vld  = 0;
      m_sel  = -1;
      m_last = 3;
   endtask

   function automatic logic [3:0] exp_thr();
      if (m_sel < 0) return 4'b0000;
      return 4'(1 << m_sel);
   endfunction

   function automatic logic [47:0] exp_pc();
      if (m_sel < 0) return 48'h0;
      return m_pc[m_sel];
   endfunction

   function automatic bit exp_kill();
      return bus.redirect_vld && m_vld && (m_sel == int'(bus.redirect_thr));
   endfunction

   task automatic model_step();
      logic [47:0] nxt [4];
      bit          kl;
      int          found;
      kl = exp_kill();
      for (int n = 0; n < 4; n++) begin
         nxt[n] = m_pc[n];
         if (bus.redirect_vld && int'(bus.redirect_thr) == n)
            nxt[n] = (bus.redirect_pc >> 2) << 2;
         else if (m_vld && m_sel == n && !bus.stall_f)
            nxt[n] = m_pc[n] + 48'd4;
      end
      if (!bus.stall_f) begin
         found = -1;
         for (int k = 1; k <= 4; k++) begin
            if (found < 0 && bus.thr_en[(m_last + k) % 4]) found = (m_last + k) % 4;
         end
         if (found >= 0) begin
            m_vld  = 1;
            m_sel  = found;
            m_last = found;
         end else begin
            m_vld = 0;
            m_sel = -1;
         end
      end else if (kl) begin
         m_vld = 0;
      end
      for (int n = 0; n < 4; n++) m_pc[n] = nxt[n];
   endtask

   task automatic check_all();
      chk("thr_f", 64'(bus.thr_f), 64'(exp_thr()));
      chk("inst_vld_f", 64'(bus.inst_vld_f), 64'(m_vld));
      chk("pc_f", 64'(bus.pc_f), 64'(exp_pc()));
      chk("t0pc_f", 64'(bus.t0pc_f), 64'(m_pc[0]));
      chk("t1pc_f", 64'(bus.t1pc_f), 64'(m_pc[1]));
      chk("t2pc_f", 64'(bus.t2pc_f), 64'(m_pc[2]));
      chk("t3pc_f", 64'(bus.t3pc_f), 64'(m_pc[3]));
      chk("kill_f", 64'(bus.kill_f), 64'(exp_kill()));
   endtask

   // inputs are set at negedge before calling; outputs sampled 1 time unit later
   task automatic cycle();
      #1 check_all();
      @(posedge clk);
      if (rst) model_reset();
      else model_step();
      @(negedge clk);
   endtask

   logic [3:0]  rr_seq [5];
   logic [47:0] held_pc;
   logic [63:0] rnd;

   initial begin
      rr_seq = '{4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};
      bus.thr_en       = 4'b0000;
      bus.stall_f      = 1'b0;
      bus.redirect_vld = 1'b0;
      bus.redirect_thr = 2'd0;
      bus.redirect_pc  = '0;
      model_reset();

      @(negedge clk);
      cycle();
      chk("rst_t3pc", 64'(bus.t3pc_f), 64'h00ff_f000_0020);

      // single strand: consecutive fetch PCs
      rst = 1'b0;
      bus.thr_en = 4'b0001;
      cycle();
      chk("t0_vld_c1", 64'(bus.inst_vld_f), 64'd1);
      chk("t0_pc_c1", 64'(bus.pc_f), 64'h00ff_f000_0020);
      cycle();
      chk("t0_pc_c2", 64'(bus.pc_f), 64'h00ff_f000_0024);
      cycle();
      chk("t0_pc_c3", 64'(bus.pc_f), 64'h00ff_f000_0028);

      // all four strands rotate
      bus.thr_en = 4'b1111;
      for (int i = 0; i < 5; i++) begin
         cycle();
         chk("rr_seq", 64'(bus.thr_f), 64'(rr_seq[i]));
      end

      // stall with T2 in F
      for (int i = 0; i < 8 && !(m_vld && m_sel == 2); i++) cycle();
      chk("wait_t2", 64'(bus.thr_f), 64'b0100);
      held_pc = m_pc[2];
      bus.stall_f = 1'b1;
      for (int i = 0; i < 3; i++) begin
         cycle();
         chk("stall_thr", 64'(bus.thr_f), 64'b0100);
         chk("stall_pc", 64'(bus.pc_f), 64'(held_pc));
      end
      bus.stall_f = 1'b0;
      cycle();
      chk("post_stall_thr", 64'(bus.thr_f), 64'b1000);

      // redirect T1 while it is in F
      for (int i = 0; i < 8 && !(m_vld && m_sel == 1); i++) cycle();
      bus.redirect_vld = 1'b1;
      bus.redirect_thr = 2'd1;
      bus.redirect_pc  = 48'h1003;
      #1 chk("redir_kill", 64'(bus.kill_f), 64'd1);
      cycle();
      bus.redirect_vld = 1'b0;
      chk("redir_t1pc", 64'(bus.t1pc_f), 64'h1000);

      // PC wrap-around
      bus.thr_en       = 4'b0001;
      bus.redirect_vld = 1'b1;
      bus.redirect_thr = 2'd0;
      bus.redirect_pc  = 48'hffff_ffff_fffc;
      cycle();
      bus.redirect_vld = 1'b0;
      chk("wrap_pre", 64'(bus.pc_f), 64'hffff_ffff_fffc);
      cycle();
      chk("wrap_t0pc", 64'(bus.t0pc_f), 64'h0);

      // async reset mid-stream with stall and redirect pending
      bus.thr_en       = 4'b1111;
      bus.stall_f      = 1'b1;
      bus.redirect_vld = 1'b1;
      bus.redirect_thr = 2'd2;
      bus.redirect_pc  = 48'h1234_5678_9abc;
      cycle();
      #1 rst = 1'b1;
      model_reset();
      #1;
      chk("arst_thr", 64'(bus.thr_f), 64'h0);
      chk("arst_vld", 64'(bus.inst_vld_f), 64'h0);
      chk("arst_pc_f", 64'(bus.pc_f), 64'h0);
      chk("arst_kill", 64'(bus.kill_f), 64'h0);
      chk("arst_t2pc", 64'(bus.t2pc_f), 64'h00ff_f000_0020);
      @(negedge clk);
      rst = 1'b0;
      bus.stall_f      = 1'b0;
      bus.redirect_vld = 1'b0;
      cycle();
      chk("arst_first", 64'(bus.thr_f), 64'b0001);

      // randomized traffic against the reference
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 3) == 0) bus.thr_en = 4'($urandom_range(0, 15));
         bus.stall_f      = ($urandom_range(0, 4) == 0);
         bus.redirect_vld = ($urandom_range(0, 5) == 0);
         bus.redirect_thr = 2'($urandom_range(0, 3));
         rnd = {$urandom, $urandom};
         if ($urandom_range(0, 3) == 0) bus.redirect_pc = 48'hffff_ffff_fff0 | 48'($urandom_range(0, 15));
         else bus.redirect_pc = rnd[47:0];
         cycle();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
